game_state_keeper: RTL and testbench

GAME_STATE_KEEPER -- requirements
Module: game_state_keeper

---
 rtl/game_state_keeper.sv | 192 +++++++++++++++++++
 tb/tb_game_state_keeper.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_keeper.sv
// Sokoban-style game state: stage maps, player/box moves with push rules,
// and an 8-deep undo history that overwrites its oldest entry when full.
module game_state_keeper #(
    parameter logic [63:0] STAGE0_WAY    = 64'h0000_3C3C_3C3C_0000,
    parameter logic [63:0] STAGE0_BOX    = 64'h0000_0000_0800_0000,
    parameter logic [63:0] STAGE0_DEST   = 64'h0000_0000_2000_0000,
    parameter logic [5:0]  STAGE0_PLAYER = 6'd26,
    parameter logic [63:0] STAGE1_WAY    = STAGE0_WAY,
    parameter logic [63:0] STAGE1_BOX    = STAGE0_BOX,
    parameter logic [63:0] STAGE1_DEST   = STAGE0_DEST,
    parameter logic [5:0]  STAGE1_PLAYER = STAGE0_PLAYER,
    parameter logic [63:0] STAGE2_WAY    = STAGE0_WAY,
    parameter logic [63:0] STAGE2_BOX    = STAGE0_BOX,
    parameter logic [63:0] STAGE2_DEST   = STAGE0_DEST,
    parameter logic [5:0]  STAGE2_PLAYER = STAGE0_PLAYER
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         game_state_en,
    input  logic [1:0]   sel,
    input  logic         stage_up,
    input  logic [5:0]   cursor,
    output logic [134:0] game_state,
    output logic [63:0]  destination,
    output logic [1:0]   stage,
    output logic         move_result,
    output logic [7:0]   move_count,
    output logic         hist_empty
);

    logic [63:0] way_q, way_d, box_q, box_d, dest_q, dest_d;
    logic [5:0]  player_q, player_d;
    logic        loaded_q, loaded_d;
    logic [1:0]  stage_q, stage_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [3:0]  depth_q, depth_d;
    logic [69:0] hist_q [8];
    logic [69:0] top;
    logic        push;

    logic [63:0] ld_way, ld_box, ld_dest;
    logic [5:0]  ld_player;

    logic [2:0]  pr, pc, tr, tc;
    logic        adj, bval;
    logic [5:0]  beyond;

    always_comb begin
        ld_way    = STAGE0_WAY;
        ld_box    = STAGE0_BOX;
        ld_dest   = STAGE0_DEST;
        ld_player = STAGE0_PLAYER;
        case (stage_q)
            2'd1: begin
                ld_way    = STAGE1_WAY;
                ld_box    = STAGE1_BOX;
                ld_dest   = STAGE1_DEST;
                ld_player = STAGE1_PLAYER;
            end
            2'd2: begin
                ld_way    = STAGE2_WAY;
                ld_box    = STAGE2_BOX;
                ld_dest   = STAGE2_DEST;
                ld_player = STAGE2_PLAYER;
            end
            default: ;
        endcase
    end

    assign pr = player_q[5:3];
    assign pc = player_q[2:0];
    assign tr = cursor[5:3];
    assign tc = cursor[2:0];

    // Row/column compares keep moves from wrapping across grid edges.
    always_comb begin
        adj    = 1'b0;
        bval   = 1'b0;
        beyond = cursor;
        if (tc == pc && {1'b0, tr} == {1'b0, pr} + 4'd1) begin
            adj    = 1'b1;
            bval   = (tr != 3'd7);
            beyond = cursor + 6'd8;
        end else if (tc == pc && {1'b0, pr} == {1'b0, tr} + 4'd1) begin
            adj    = 1'b1;
            bval   = (tr != 3'd0);
            beyond = cursor - 6'd8;
        end else if (tr == pr && {1'b0, tc} == {1'b0, pc} + 4'd1) begin
            adj    = 1'b1;
            bval   = (tc != 3'd7);
            beyond = cursor + 6'd1;
        end else if (tr == pr && {1'b0, pc} == {1'b0, tc} + 4'd1) begin
            adj    = 1'b1;
            bval   = (tc != 3'd0);
            beyond = cursor - 6'd1;
        end
    end

    assign move_result = adj & way_q[cursor] &
        (~box_q[cursor] | (bval & way_q[beyond] & ~box_q[beyond]));

    assign top = hist_q[ptr_q - 3'd1];

    always_comb begin
        way_d    = way_q;
        box_d    = box_q;
        dest_d   = dest_q;
        player_d = player_q;
        loaded_d = loaded_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        depth_d  = depth_q;
        push     = 1'b0;
        if (game_state_en) begin
            unique case (sel)
                2'd0: begin
                    way_d    = ld_way;
                    box_d    = ld_box;
                    dest_d   = ld_dest;
                    player_d = ld_player;
                    loaded_d = 1'b1;
                    ptr_d    = 3'd0;
                    depth_d  = 4'd0;
                    cnt_d    = 8'd0;
                end
                2'd1: begin
                    if (move_result) begin
                        push     = 1'b1;
                        player_d = cursor;
                        if (box_q[cursor])
                            box_d = (box_q & ~(64'd1 << cursor)) |
                                    (64'd1 << beyond);
                        ptr_d   = ptr_q + 3'd1;
                        depth_d = (depth_q == 4'd8) ? 4'd8 : depth_q + 4'd1;
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
                end
                2'd3: begin
                    if (depth_q != 4'd0) begin
                        box_d    = top[69:6];
                        player_d = top[5:0];
                        ptr_d    = ptr_q - 3'd1;
                        depth_d  = depth_q - 4'd1;
                        cnt_d    = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
        if (stage_up && stage_q != 2'd2)
            stage_d = stage_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            way_q    <= STAGE0_WAY;
            box_q    <= STAGE0_BOX;
            dest_q   <= STAGE0_DEST;
            player_q <= STAGE0_PLAYER;
            loaded_q <= 1'b1;
            stage_q  <= 2'd0;
            cnt_q    <= 8'd0;
            ptr_q    <= 3'd0;
            depth_q  <= 4'd0;
        end else begin
            way_q    <= way_d;
            box_q    <= box_d;
            dest_q   <= dest_d;
            player_q <= player_d;
            loaded_q <= loaded_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            depth_q  <= depth_d;
        end
    end

    // History storage needs no reset; depth_q says which entries are live.
    always_ff @(posedge clk) begin
        if (push && !reset)
            hist_q[ptr_q] <= {box_q, player_q};
    end

    assign game_state  = {loaded_q, way_q, box_q, player_q};
    assign destination = dest_q;
    assign stage       = stage_q;
    assign move_count  = cnt_q;
    assign hist_empty  = (depth_q == 4'd0);

endmodule

// File: tb/tb_game_state_keeper.sv
// Scoreboard bench for game_state_keeper: directed scenarios then random
// commands, compared against a grid-level reference model.
module tb_game_state_keeper;

    localparam logic [63:0] S0_WAY  = 64'h0000_3C3C_3C3C_0000;
    localparam logic [63:0] S0_BOX  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] S0_DEST = 64'h0000_0000_2000_0000;
    localparam logic [5:0]  S0_PL   = 6'd26;
    localparam logic [63:0] S1_WAY  = 64'h0000_7E7E_7E7E_0000;
    localparam logic [63:0] S1_BOX  = 64'h0000_0000_1000_0000;
    localparam logic [63:0] S1_DEST = 64'h0000_0002_0000_0000;
    localparam logic [5:0]  S1_PL   = 6'd18;
    localparam logic [63:0] S2_WAY  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] S2_BOX  = 64'h0000_0018_1800_0000;
    localparam logic [63:0] S2_DEST = 64'h0000_0000_0000_00FF;
    localparam logic [5:0]  S2_PL   = 6'd0;

    logic         clk = 0;
    logic         reset = 0;
    logic         game_state_en = 0;
    logic [1:0]   sel = 0;
    logic         stage_up = 0;
    logic [5:0]   cursor = 0;
    logic [134:0] game_state;
    logic [63:0]  destination;
    logic [1:0]   stage;
    logic         move_result;
    logic [7:0]   move_count;
    logic         hist_empty;

    game_state_keeper #(
        .STAGE0_WAY(S0_WAY), .STAGE0_BOX(S0_BOX),
        .STAGE0_DEST(S0_DEST), .STAGE0_PLAYER(S0_PL),
        .STAGE1_WAY(S1_WAY), .STAGE1_BOX(S1_BOX),
        .STAGE1_DEST(S1_DEST), .STAGE1_PLAYER(S1_PL),
        .STAGE2_WAY(S2_WAY), .STAGE2_BOX(S2_BOX),
        .STAGE2_DEST(S2_DEST), .STAGE2_PLAYER(S2_PL)
    ) dut (
        .clk(clk), .reset(reset), .game_state_en(game_state_en),
        .sel(sel), .stage_up(stage_up), .cursor(cursor),
        .game_state(game_state), .destination(destination),
        .stage(stage), .move_result(move_result),
        .move_count(move_count), .hist_empty(hist_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [134:0] gs;
        logic [63:0]  dest;
        logic [1:0]   stg;
        logic [7:0]   cnt;
        logic         he;
    } exp_t;

    exp_t st_q[$];
    bit   mr_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: grid as bit vectors, history as a bounded queue.
    logic [63:0] m_way, m_box, m_dest;
    int          m_p;
    int          m_stage;
    int          m_cnt;
    bit          m_loaded;
    bit          m_init = 0;
    logic [69:0] m_hist[$];

    task automatic chk(string n, logic [134:0] got, logic [134:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic m_load(int s);
        case (s)
            1: begin
                m_way = S1_WAY; m_box = S1_BOX;
                m_dest = S1_DEST; m_p = int'(S1_PL);
            end
            2: begin
                m_way = S2_WAY; m_box = S2_BOX;
                m_dest = S2_DEST; m_p = int'(S2_PL);
            end
            default: begin
                m_way = S0_WAY; m_box = S0_BOX;
                m_dest = S0_DEST; m_p = int'(S0_PL);
            end
        endcase
        m_loaded = 1;
        m_hist.delete();
        m_cnt = 0;
    endtask

    function automatic int m_beyond(int t);
        int dr, dc;
        dr = t / 8 - m_p / 8;
        dc = t % 8 - m_p % 8;
        if (t / 8 + dr < 0 || t / 8 + dr > 7) return -1;
        if (t % 8 + dc < 0 || t % 8 + dc > 7) return -1;
        return (t / 8 + dr) * 8 + (t % 8 + dc);
    endfunction

    function automatic bit m_legal(int t);
        int dr, dc, b;
        dr = t / 8 - m_p / 8;
        dc = t % 8 - m_p % 8;
        if (dr * dr + dc * dc != 1) return 0;
        if (!m_way[t]) return 0;
        if (!m_box[t]) return 1;
        b = m_beyond(t);
        if (b < 0) return 0;
        return m_way[b] && !m_box[b];
    endfunction

    task automatic step(bit rst, bit en, logic [1:0] s, bit up, int cur);
        bit   ok;
        int   t, b;
        exp_t e;
        logic [69:0] h;
        @(negedge clk);
        t = cur & 63;
        reset = rst;
        game_state_en = en;
        sel = s;
        stage_up = up;
        cursor = 6'(t);
        ok = m_init ? m_legal(t) : 1'b0;
        if (m_init) mr_q.push_back(ok);
        if (rst) begin
            m_load(0);
            m_stage = 0;
            m_init = 1;
        end else begin
            if (en && s == 2'd0) begin
                m_load(m_stage);
            end else if (en && s == 2'd1 && ok) begin
                m_hist.push_back({m_box, 6'(m_p)});
                if (m_hist.size() > 8) void'(m_hist.pop_front());
                if (m_box[t]) begin
                    b = m_beyond(t);
                    m_box[t] = 1'b0;
                    m_box[b] = 1'b1;
                end
                m_p = t;
                if (m_cnt < 255) m_cnt++;
            end else if (en && s == 2'd3 && m_hist.size() > 0) begin
                h = m_hist.pop_back();
                m_box = h[69:6];
                m_p = int'(h[5:0]);
                if (m_cnt > 0) m_cnt--;
            end
            if (up && m_stage < 2) m_stage++;
        end
        e.gs   = {m_loaded, m_way, m_box, 6'(m_p)};
        e.dest = m_dest;
        e.stg  = 2'(m_stage);
        e.cnt  = 8'(m_cnt);
        e.he   = (m_hist.size() == 0);
        st_q.push_back(e);
    endtask

    initial begin : mon_comb
        bit x;
        forever begin
            @(negedge clk);
            #2;
            if (mr_q.size() > 0) begin
                x = mr_q.pop_front();
                chk("move_result", 135'(move_result), 135'(x));
            end
        end
    end

    initial begin : mon_state
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("game_state", game_state, e.gs);
                chk("destination", 135'(destination), 135'(e.dest));
                chk("stage", 135'(stage), 135'(e.stg));
                chk("move_count", 135'(move_count), 135'(e.cnt));
                chk("hist_empty", 135'(hist_empty), 135'(e.he));
            end
        end
    end

    int mv[9] = '{27, 19, 20, 21, 29, 37, 36, 35, 34};

    initial begin : drive
        int r, c, d;
        step(1, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("rst_player", 135'(game_state[5:0]), 135'(26));
        chk("rst_box", 135'(game_state[69:6]), 135'(64'h0800_0000));
        chk("rst_dest", 135'(destination), 135'(64'h2000_0000));
        chk("rst_loaded", 135'(game_state[134]), 135'(1));

        step(0, 0, 0, 0, 27);
        step(0, 1, 1, 0, 27);
        step(0, 1, 1, 0, 28);
        @(posedge clk); #2;
        chk("box_on_dest", 135'(game_state[69:6]), 135'(destination));

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 25);
        step(0, 0, 0, 0, 34);
        step(0, 1, 1, 0, 34);
        step(0, 1, 1, 0, 25);

        step(1, 0, 0, 0, 0);
        foreach (mv[i]) step(0, 1, 1, 0, mv[i]);
        repeat (9) step(0, 1, 3, 0, 0);
        @(posedge clk); #2;
        chk("undo_floor_cnt", 135'(move_count), 135'(1));

        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 56);
        for (int i = 1; i < 8; i++) step(0, 1, 1, 0, i);
        step(0, 1, 1, 0, 8);
        step(0, 1, 1, 0, 15);
        step(0, 1, 2, 0, 14);

        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 27);
        step(0, 1, 1, 0, 28);
        step(1, 1, 1, 0, 20);
        @(posedge clk); #2;
        chk("rst_mid_player", 135'(game_state[5:0]), 135'(26));

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            c = int'($urandom_range(0, 99));
            d = int'($urandom_range(0, 3));
            if (c < 80)
                c = m_p + ((d == 0) ? 1 : (d == 1) ? -1 : (d == 2) ? 8 : -8);
            else
                c = int'($urandom_range(0, 63));
            step(r == 0,
                 $urandom_range(0, 3) != 0,
                 (r < 50) ? 2'd1 : (r < 75) ? 2'd3 : (r < 85) ? 2'd0 : 2'd2,
                 $urandom_range(0, 39) == 0,
                 c);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(posedge clk); #3;
        chk("queues_drained", 135'(st_q.size() + mr_q.size()), 135'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
